// File: rtl/cnn_pkg.sv
// cnn_pkg: types and constants shared by the pooling-stream sink.
//   N    - maximum input image dimension (buffer holds N*N pixels)
//   DW   - pixel width, signed fixed point
//   AW   - address width of the N*N output buffer
//   pix_t      - signed pixel type
//   wr_state_t - writer FSM states
//   sizes_legal() - accepts an img/window pair the writer can map
package cnn_pkg;

    localparam int N  = 32;
    localparam int DW = 16;
    localparam int AW = $clog2(N * N);

    typedef logic signed [DW-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE,
        SIZE,
        COLLECT,
        DONE
    } wr_state_t;

    // A window must be non-zero and fit inside a non-empty image that fits the buffer.
    function automatic logic sizes_legal(input logic [15:0] img, input logic [15:0] win);
        return (win != 16'd0) && (img != 16'd0) && (win <= img) && (img <= 16'(N));
    endfunction

endpackage

// File: rtl/pool_dim_calc.sv
// pool_dim_calc: divider-free sizer computing floor(img_size/window_size) by
// repeated addition of the window to an accumulator, one step per cycle.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   start        - latch img_size/window_size, clear dim; run only if sizes are legal
//   img_size     - input image dimension
//   window_size  - pooling window / stride
//   dim          - output dimension; holds until the next start or reset
//   dim_valid    - high in the final sizing cycle (next window would overrun)
module pool_dim_calc
    import cnn_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] img_size,
    input  logic [15:0] window_size,
    output logic [15:0] dim,
    output logic        dim_valid
);

    logic [16:0] acc;
    logic [16:0] acc_next;
    logic [15:0] img_q;
    logic [15:0] win_q;
    logic        running;
    logic        fits;

    // acc never exceeds img_size (<= N), so 17 bits cannot overflow.
    assign acc_next  = acc + {1'b0, win_q};
    assign fits      = (acc_next <= {1'b0, img_q});
    assign dim_valid = running && !fits;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            dim     <= '0;
            img_q   <= '0;
            win_q   <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            dim     <= '0;
            img_q   <= img_size;
            win_q   <= window_size;
            running <= sizes_legal(img_size, window_size);
        end else if (running) begin
            if (fits) begin
                acc <= acc_next;
                dim <= dim + 16'd1;
            end else begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pool_map_writer.sv
// pool_map_writer: sink of the pooling stream. Accepts pooled pixels in
// raster-window order and writes them row-major into an output feature map
// of out_dim x out_dim, out_dim = floor(img_size/window_size).
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   start        - 1-cycle pulse in IDLE: latch sizes, clear map, begin
//   img_size     - input image dimension, sampled on start
//   window_size  - pooling window/stride, sampled on start
//   in_valid     - in_data carries a pooled pixel
//   in_data      - signed pooled pixel
//   in_ready     - pixel accepted this cycle (COLLECT only)
//   out_map      - N*N signed map, row-major with stride out_dim
//   out_dim      - output dimension
//   busy         - high while sizing or collecting
//   done         - 1-cycle pulse when the map is complete (or rejected)
//   err          - sticky until next start: illegal sizes
module pool_map_writer
    import cnn_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] img_size,
    input  logic [15:0] window_size,
    input  logic        in_valid,
    input  pix_t        in_data,
    output logic        in_ready,
    output pix_t        out_map [N*N],
    output logic [15:0] out_dim,
    output logic        busy,
    output logic        done,
    output logic        err
);

    wr_state_t state;
    wr_state_t state_next;

    logic        start_acc;
    logic        legal;
    logic        dim_valid;
    logic        xfer;
    logic        last_pixel;
    logic [15:0] row;
    logic [15:0] col;
    logic [15:0] dim_m1;
    logic [AW-1:0] wr_idx;

    assign start_acc  = (state == IDLE) && start;
    assign legal      = sizes_legal(img_size, window_size);
    assign xfer       = in_valid && in_ready;
    assign dim_m1     = out_dim - 16'd1;
    assign last_pixel = (row == dim_m1) && (col == dim_m1);
    // row*out_dim+col stays below N*N, so the low AW bits are the full index.
    assign wr_idx     = AW'(row * out_dim + col);

    pool_dim_calc u_dim_calc (
        .clk         (clk),
        .reset       (reset),
        .start       (start_acc),
        .img_size    (img_size),
        .window_size (window_size),
        .dim         (out_dim),
        .dim_valid   (dim_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = legal ? SIZE : DONE;
            SIZE:    if (dim_valid) state_next = COLLECT;
            COLLECT: if (xfer && last_pixel) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state alone.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE:    ;
            SIZE:    busy = 1'b1;
            COLLECT: begin
                busy     = 1'b1;
                in_ready = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Map buffer, raster counters and sticky error.
    // NOTE: the buffer is cleared by reset and on start because the next layer
    // reads every entry and must see zeros outside the current out_dim window.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N*N; i++) out_map[i] <= '0;
            row <= '0;
            col <= '0;
            err <= 1'b0;
        end else if (start_acc) begin
            for (int i = 0; i < N*N; i++) out_map[i] <= '0;
            row <= '0;
            col <= '0;
            err <= !legal;
        end else if (xfer) begin
            out_map[wr_idx] <= in_data;
            if (col == dim_m1) begin
                col <= '0;
                row <= row + 16'd1;
            end else begin
                col <= col + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pool_map_writer.sv
module tb_pool_map_writer;
    import cnn_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] img_size;
    logic [15:0] window_size;
    logic        in_valid;
    pix_t        in_data;
    logic        in_ready;
    pix_t        out_map [N*N];
    logic [15:0] out_dim;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        int   idx;
        pix_t val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pool_map_writer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .img_size    (img_size),
        .window_size (window_size),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_map     (out_map),
        .out_dim     (out_dim),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int img, input int win);
        start       = 1'b1;
        img_size    = 16'(img);
        window_size = 16'(win);
        step();
        start = 1'b0;
    endtask

    // Wait (bounded) for in_ready; n counts observed SIZE cycles.
    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 200) begin
            n++;
            step();
        end
    endtask

    // Send cnt pixels with raster indices first..first+cnt-1, values base+k.
    task automatic send_pixels(input int first, input int cnt, input int base, input bit gap);
        for (int k = 0; k < cnt; k++) begin
            if (gap) begin
                in_valid = 1'b0;
                in_data  = pix_t'($urandom);
                step();
            end
            check($sformatf("ready_px%0d", first + k), in_ready, 1);
            in_valid = 1'b1;
            in_data  = pix_t'(base + k);
            sb.push_back('{idx: first + k, val: pix_t'(base + k)});
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_map();
        check("done_pulse", done, 1);
        check("done_ready", in_ready, 0);
        check("done_busy", busy, 0);
        step();
        check("done_low", done, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("map[%0d]", e.idx), out_map[e.idx], e.val);
        end
    endtask

    task automatic full_map(input int img, input int win, input int base, input bit gap);
        int n;
        int exp_dim;
        exp_dim = img / win;
        do_start(img, win);
        check("sz_busy", busy, 1);
        check("sz_err", err, 0);
        wait_ready(n);
        check("size_cycles", n, exp_dim + 1);
        check("out_dim", out_dim, exp_dim);
        send_pixels(0, exp_dim * exp_dim, base, gap);
        finish_map();
    endtask

    initial begin : stim
        int n;
        reset       = 1'b1;
        start       = 1'b0;
        img_size    = '0;
        window_size = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        step();
        step();
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_dim", out_dim, 0);
        check("rst_map0", out_map[0], 0);
        check("rst_map_last", out_map[N*N-1], 0);
        reset = 1'b0;
        step();

        // 1: 4/2, back-to-back pixels.
        full_map(4, 2, 1, 1'b0);
        drain();

        // 2: 5/2, in_valid toggling; extra valid beats after done are dropped.
        full_map(5, 2, -3, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'sd77;
        for (int k = 0; k < 3; k++) begin
            check("post_done", done, 0);
            check("post_ready", in_ready, 0);
            step();
        end
        in_valid = 1'b0;
        check("map4_untouched", out_map[4], 0);
        drain();

        // 3: illegal sizes.
        do_start(4, 0);
        check("w0_done", done, 1);
        check("w0_err", err, 1);
        check("w0_ready", in_ready, 0);
        check("w0_dim", out_dim, 0);
        step();
        check("w0_done_low", done, 0);
        check("w0_err_sticky", err, 1);
        do_start(4, 8);
        check("wbig_done", done, 1);
        check("wbig_err", err, 1);
        check("wbig_ready", in_ready, 0);
        check("wbig_dim", out_dim, 0);
        check("wbig_map_cleared", out_map[0], 0);
        step();
        do_start(33, 1);
        check("ibig_done", done, 1);
        check("ibig_err", err, 1);
        step();

        // 4: reset mid-COLLECT discards the partial map, then restart.
        do_start(4, 2);
        wait_ready(n);
        send_pixels(0, 2, 11, 1'b0);
        sb.delete();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_dim", out_dim, 0);
        check("mid_rst_map0", out_map[0], 0);
        check("mid_rst_map1", out_map[1], 0);
        full_map(4, 2, 5, 1'b0);
        check("restart_err", err, 0);
        drain();

        // 5: in_valid during SIZE and start during COLLECT are ignored.
        do_start(4, 2);
        in_valid = 1'b1;
        in_data  = 16'sd99;
        step();
        in_valid = 1'b0;
        wait_ready(n);
        check("ign_dim", out_dim, 2);
        send_pixels(0, 2, 21, 1'b0);
        start       = 1'b1;
        img_size    = 16'd8;
        window_size = 16'd1;
        step();
        start = 1'b0;
        check("ign_start_ready", in_ready, 1);
        check("ign_start_dim", out_dim, 2);
        check("ign_start_err", err, 0);
        send_pixels(2, 2, 23, 1'b0);
        finish_map();
        drain();

        // 6: full 32x32 map, value = index; next start clears it.
        full_map(32, 1, 0, 1'b0);
        drain();
        do_start(4, 2);
        check("clr_map5", out_map[5], 0);
        check("clr_map_last", out_map[N*N-1], 0);
        wait_ready(n);
        send_pixels(0, 4, 40, 1'b0);
        finish_map();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
